alarm_trigger_module: RTL and testbench
=======================================

# alarm_trigger_module

Downstream consumer of the set-time stage: watches the running day/time word and the seven per-day alarm registers, and drives the alarm bell. It raises RING when the current time first matches an enabled alarm for the current day. It also handles STOP, a bounded number of snoozes, and an automatic ring timeout counted in minute ticks. All state is in one clock domain.

## Interface
Parameters:
- RING_MIN, default 5: minutes RING stays high before auto-stop (1..15).
- SNOOZE_MIN, default 9: minutes of silence per snooze (1..15).
- MAX_SNOOZE, default 3: snoozes allowed per alarm event (0..3).

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- CLEAR  in  1  reset, synchronous, active-high.
- CT  in  15  current time: [14:12] day 0-6, [11:7] hour 0-23, [6:4] minute tens 0-5, [3:0] minute units 0-9.
- Q_r0..Q_r6  in  13 each  alarm for day 0..6: [12] enable, [11:0] hour/minute, same packing as CT[11:0].
- MASTER_EN  in  1  global alarm on/off (the on/off bit of the set-time output word).
- MIN_TICK  in  1  one-cycle pulse on each minute rollover.
- STOP  in  1  user stop, level sampled each cycle.
- SNOOZE  in  1  user snooze, level sampled each cycle.
- RING  out  1  bell drive, registered.
- SNOOZING  out  1  high in SNOOZE_WAIT, registered.
- SNOOZE_CNT  out  2  snoozes used in the current event, registered.

## Operation
- Alarm select: sel = Q_r[CT[14:12]]. Day value 7 selects nothing, so match = 0.
- Match condition: match = MASTER_EN & sel[12] & (sel[11:0] == CT[11:0]).
- Edge detection: match_q is a registered copy of match. trigger = match & ~match_q, so one event fires per matching minute.
- States: IDLE, RINGING, SNOOZE_WAIT. One timer, tmr[3:0], counts MIN_TICK pulses.
- IDLE:
  - trigger -> RINGING, tmr = 0, SNOOZE_CNT = 0.
- RINGING, priority STOP > SNOOZE > timeout:
  - STOP -> IDLE.
  - SNOOZE with SNOOZE_CNT < MAX_SNOOZE -> SNOOZE_WAIT, tmr = 0, SNOOZE_CNT + 1.
  - SNOOZE with the snooze count exhausted is treated as STOP.
  - MIN_TICK -> tmr + 1. When tmr + 1 == RING_MIN -> IDLE.
- SNOOZE_WAIT:
  - STOP -> IDLE.
  - SNOOZE is ignored.
  - MIN_TICK -> tmr + 1. When tmr + 1 == SNOOZE_MIN -> RINGING, tmr = 0.
- In any state, MASTER_EN = 0 -> IDLE next edge. This has priority over everything except CLEAR.
- Outside IDLE, trigger is ignored (no restart, SNOOZE_CNT unchanged).
- On returning to IDLE, SNOOZE_CNT holds its value until the next trigger. Only CLEAR zeroes it early.
- Alarm registers or CT changing mid-event does not affect the event in progress.

## Timing
- Reset values: state IDLE, RING 0, SNOOZING 0, SNOOZE_CNT 0, tmr 0, match_q 1.
  - match_q resets to 1 so a match already present at reset release does not fire.
- CLEAR has priority over all inputs. Reset asserted mid-ring clears RING on the next edge.
- Trigger latency: the edge that samples trigger = 1 enters RINGING. RING is high in the following cycle (1 cycle).
- STOP or SNOOZE sampled at edge n -> RING low from edge n.
- Snooze re-ring: RING returns at the edge sampling the SNOOZE_MIN-th MIN_TICK after the snooze edge.
- Timeout: RING drops at the edge sampling the RING_MIN-th MIN_TICK after entry.
  - A MIN_TICK on the entry edge itself is not counted.
- Simultaneous STOP and SNOOZE: STOP wins.
- Simultaneous STOP/SNOOZE and MIN_TICK: the button wins and the tick is not counted.
- match_q updates every cycle in every state.

## Test plan
- Day 2, Q_r2 = {1, 07:30}, MASTER_EN = 1, CT steps 07:29 -> 07:30 -> RING = 1 one cycle after CT = 07:30; RING stays high for 5 MIN_TICKs, then 0.
- Ring, then SNOOZE pulse -> RING = 0, SNOOZING = 1, SNOOZE_CNT = 1; after 9 MIN_TICKs, RING = 1 again. Repeat until SNOOZE_CNT = 3; a 4th SNOOZE -> IDLE, RING = 0.
- Ring, then STOP and SNOOZE in the same cycle -> IDLE, SNOOZE_CNT stays 0; CT held at 07:30 for 100 further cycles -> no retrigger.
- Matching time with Q_r2[12] = 0, or MASTER_EN = 0, or CT day = 7 -> RING stays 0. Dropping MASTER_EN during SNOOZE_WAIT -> IDLE next edge.
- CT = alarm time while CLEAR is released -> no ring that minute; the next day's match with Q_r3 = {1, 07:30} -> rings.
- CLEAR asserted in RINGING with SNOOZE_CNT = 2 -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/alarm_trigger_module_if.sv
// Signal bundle between the set-time stage / user buttons and the alarm trigger.
// The master side drives time, alarm registers and buttons; the slave side drives the bell outputs.
interface alarm_trigger_module_if;
    logic [14:0] CT;
    logic [12:0] Q_r0;
    logic [12:0] Q_r1;
    logic [12:0] Q_r2;
    logic [12:0] Q_r3;
    logic [12:0] Q_r4;
    logic [12:0] Q_r5;
    logic [12:0] Q_r6;
    logic        MASTER_EN;
    logic        MIN_TICK;
    logic        STOP;
    logic        SNOOZE;
    logic        RING;
    logic        SNOOZING;
    logic [1:0]  SNOOZE_CNT;

    modport master (
        output CT, Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6,
        output MASTER_EN, MIN_TICK, STOP, SNOOZE,
        input  RING, SNOOZING, SNOOZE_CNT
    );

    modport slave (
        input  CT, Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6,
        input  MASTER_EN, MIN_TICK, STOP, SNOOZE,
        output RING, SNOOZING, SNOOZE_CNT
    );
endinterface

// File: rtl/alarm_trigger_module.sv
// Alarm bell controller: fires once per matching minute, then handles stop,
// a bounded number of snoozes and an automatic ring timeout counted in minute ticks.
module alarm_trigger_module #(
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                  Clk,
    input  logic                  CLEAR,
    alarm_trigger_module_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RINGING     = 2'd1,
        SNOOZE_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] RING_LIM   = 4'(RING_MIN);
    localparam logic [3:0] SNOOZE_LIM = 4'(SNOOZE_MIN);
    localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

    state_t      state_reg, state_next;
    logic [3:0]  tmr_reg, tmr_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        match_q_reg;
    logic        ring_reg, ring_next;
    logic        snoozing_reg, snoozing_next;

    logic [12:0] alarm_sel [7];
    logic [7:0]  day_hit;
    logic        match;
    logic        trigger;
    logic [3:0]  tmr_inc;

    assign alarm_sel[0] = bus.Q_r0;
    assign alarm_sel[1] = bus.Q_r1;
    assign alarm_sel[2] = bus.Q_r2;
    assign alarm_sel[3] = bus.Q_r3;
    assign alarm_sel[4] = bus.Q_r4;
    assign alarm_sel[5] = bus.Q_r5;
    assign alarm_sel[6] = bus.Q_r6;

    // One hit line per weekday; day code 7 has no register and never matches.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_day
            assign day_hit[gi] = (bus.CT[14:12] == 3'(gi)) && alarm_sel[gi][12]
                                 && (alarm_sel[gi][11:0] == bus.CT[11:0]);
        end
    endgenerate
    assign day_hit[7] = 1'b0;

    assign match   = bus.MASTER_EN & (|day_hit);
    assign trigger = match & ~match_q_reg;
    assign tmr_inc = tmr_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        cnt_next   = cnt_reg;
        if (!bus.MASTER_EN) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        state_next = RINGING;
                        tmr_next   = 4'd0;
                        cnt_next   = 2'd0;
                    end
                end
                RINGING: begin
                    // Buttons outrank the tick, so a tick in the same cycle is dropped.
                    if (bus.STOP) begin
                        state_next = IDLE;
                    end else if (bus.SNOOZE) begin
                        if (cnt_reg < SNOOZE_MAX) begin
                            state_next = SNOOZE_WAIT;
                            tmr_next   = 4'd0;
                            cnt_next   = cnt_reg + 2'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (bus.MIN_TICK) begin
                        tmr_next = tmr_inc;
                        if (tmr_inc == RING_LIM) begin
                            state_next = IDLE;
                        end
                    end
                end
                SNOOZE_WAIT: begin
                    if (bus.STOP) begin
                        state_next = IDLE;
                    end else if (bus.MIN_TICK) begin
                        if (tmr_inc == SNOOZE_LIM) begin
                            state_next = RINGING;
                            tmr_next   = 4'd0;
                        end else begin
                            tmr_next = tmr_inc;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        ring_next     = (state_next == RINGING);
        snoozing_next = (state_next == SNOOZE_WAIT);
    end

    // match_q resets high so a match already present at reset release is not an edge.
    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            state_reg    <= IDLE;
            tmr_reg      <= 4'd0;
            cnt_reg      <= 2'd0;
            match_q_reg  <= 1'b1;
            ring_reg     <= 1'b0;
            snoozing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            cnt_reg      <= cnt_next;
            match_q_reg  <= match;
            ring_reg     <= ring_next;
            snoozing_reg <= snoozing_next;
        end
    end

    assign bus.RING       = ring_reg;
    assign bus.SNOOZING   = snoozing_reg;
    assign bus.SNOOZE_CNT = cnt_reg;
endmodule

// File: tb/tb_alarm_trigger_module.sv
// Directed and randomized checks of the alarm trigger against a countdown-style
// behavioural model of the bell (minutes left ringing / minutes left snoozing).
module tb_alarm_trigger_module;
    localparam int RING_MIN   = 5;
    localparam int SNOOZE_MIN = 9;
    localparam int MAX_SNOOZE = 3;

    logic clk = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Model state: minutes remaining in the current ring / snooze, 0 means not in it.
    int   m_ring_left = 0;
    int   m_snz_left = 0;
    int   m_cnt = 0;
    bit   m_prev_match = 1'b1;

    always #5 clk = ~clk;

    alarm_trigger_module_if bus ();

    alarm_trigger_module #(
        .RING_MIN  (RING_MIN),
        .SNOOZE_MIN(SNOOZE_MIN),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .Clk  (clk),
        .CLEAR(clear),
        .bus  (bus)
    );

    function automatic logic [11:0] hm(input int h, input int m);
        return {5'(h), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [14:0] mk_ct(input int d, input int h, input int m);
        return {3'(d), hm(h, m)};
    endfunction

    function automatic logic [12:0] alarm_of(input int d);
        case (d)
            0: return bus.Q_r0;
            1: return bus.Q_r1;
            2: return bus.Q_r2;
            3: return bus.Q_r3;
            4: return bus.Q_r4;
            5: return bus.Q_r5;
            6: return bus.Q_r6;
            default: return 13'd0;
        endcase
    endfunction

    function automatic bit model_match();
        int d;
        logic [12:0] a;
        d = int'(bus.CT[14:12]);
        if (d == 7) return 1'b0;
        a = alarm_of(d);
        return bus.MASTER_EN && a[12] && (a[11:0] == bus.CT[11:0]);
    endfunction

    task automatic model_edge();
        bit m;
        bit trig;
        if (clear) begin
            m_ring_left  = 0;
            m_snz_left   = 0;
            m_cnt        = 0;
            m_prev_match = 1'b1;
            return;
        end
        m = model_match();
        trig = m && !m_prev_match;
        m_prev_match = m;
        if (!bus.MASTER_EN) begin
            m_ring_left = 0;
            m_snz_left  = 0;
        end else if (m_ring_left > 0) begin
            if (bus.STOP) begin
                m_ring_left = 0;
            end else if (bus.SNOOZE) begin
                m_ring_left = 0;
                if (m_cnt < MAX_SNOOZE) begin
                    m_cnt++;
                    m_snz_left = SNOOZE_MIN;
                end
            end else if (bus.MIN_TICK) begin
                m_ring_left--;
            end
        end else if (m_snz_left > 0) begin
            if (bus.STOP) begin
                m_snz_left = 0;
            end else if (bus.MIN_TICK) begin
                m_snz_left--;
                if (m_snz_left == 0) m_ring_left = RING_MIN;
            end
        end else if (trig) begin
            m_ring_left = RING_MIN;
            m_cnt = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".ring"}, {1'b0, bus.RING}, {1'b0, m_ring_left > 0});
        chk({tag, ".snoozing"}, {1'b0, bus.SNOOZING}, {1'b0, m_snz_left > 0});
        chk({tag, ".cnt"}, bus.SNOOZE_CNT, 2'(m_cnt));
    endtask

    task automatic tick(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.MIN_TICK = 1'b1;
            cycle(tag);
            bus.MIN_TICK = 1'b0;
            cycle(tag);
        end
    endtask

    task automatic press(input bit stop, input bit snooze, input string tag);
        bus.STOP = stop;
        bus.SNOOZE = snooze;
        cycle(tag);
        bus.STOP = 1'b0;
        bus.SNOOZE = 1'b0;
    endtask

    task automatic fire(input int d, input string tag);
        bus.CT = mk_ct(d, 7, 31);
        cycle(tag);
        bus.CT = mk_ct(d, 7, 30);
        cycle(tag);
    endtask

    initial begin
        bus.CT = mk_ct(2, 7, 29);
        bus.Q_r0 = 13'd0; bus.Q_r1 = 13'd0; bus.Q_r2 = {1'b1, hm(7, 30)};
        bus.Q_r3 = 13'd0; bus.Q_r4 = 13'd0; bus.Q_r5 = 13'd0; bus.Q_r6 = 13'd0;
        bus.MASTER_EN = 1'b1;
        bus.MIN_TICK = 1'b0;
        bus.STOP = 1'b0;
        bus.SNOOZE = 1'b0;

        $display("step reset");
        repeat (3) cycle("reset");
        chk("reset_ring", {1'b0, bus.RING}, 2'd0);
        chk("reset_cnt", bus.SNOOZE_CNT, 2'd0);
        clear = 1'b0;
        repeat (2) cycle("pre");

        $display("step trigger_and_timeout");
        bus.CT = mk_ct(2, 7, 30);
        cycle("trig");
        chk("trig_ring", {1'b0, bus.RING}, 2'd1);
        tick(4, "ringing");
        chk("ring_after_4", {1'b0, bus.RING}, 2'd1);
        tick(1, "timeout");
        chk("timeout_ring", {1'b0, bus.RING}, 2'd0);
        repeat (5) cycle("no_retrig");

        $display("step snooze_sequence");
        fire(2, "snz_fire");
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            press(1'b0, 1'b1, "snz_press");
            chk("snz_ring", {1'b0, bus.RING}, 2'd0);
            chk("snz_cnt", bus.SNOOZE_CNT, 2'(k));
            tick(8, "snz_wait");
            chk("snz_still_quiet", {1'b0, bus.RING}, 2'd0);
            tick(1, "snz_rering");
            chk("snz_rering", {1'b0, bus.RING}, 2'd1);
        end
        press(1'b0, 1'b1, "snz_exhausted");
        chk("exhaust_ring", {1'b0, bus.RING}, 2'd0);
        chk("exhaust_snoozing", {1'b0, bus.SNOOZING}, 2'd0);
        chk("exhaust_cnt", bus.SNOOZE_CNT, 2'd3);

        $display("step stop_and_snooze_together");
        fire(2, "both_fire");
        chk("both_fire_cnt", bus.SNOOZE_CNT, 2'd0);
        press(1'b1, 1'b1, "both_press");
        chk("both_ring", {1'b0, bus.RING}, 2'd0);
        repeat (100) cycle("hold_0730");
        chk("hold_ring", {1'b0, bus.RING}, 2'd0);

        $display("step non_ringing_cases");
        bus.Q_r2[12] = 1'b0;
        fire(2, "disabled");
        repeat (3) cycle("disabled");
        bus.Q_r2[12] = 1'b1;
        bus.CT = mk_ct(2, 7, 31);
        cycle("master_off");
        bus.MASTER_EN = 1'b0;
        bus.CT = mk_ct(2, 7, 30);
        repeat (3) cycle("master_off");
        chk("master_off_ring", {1'b0, bus.RING}, 2'd0);
        bus.CT = mk_ct(2, 7, 31);
        cycle("master_on");
        bus.MASTER_EN = 1'b1;
        bus.Q_r0 = {1'b1, hm(7, 30)};
        fire(7, "day7");
        repeat (3) cycle("day7");
        chk("day7_ring", {1'b0, bus.RING}, 2'd0);
        fire(2, "drop_fire");
        press(1'b0, 1'b1, "drop_snooze");
        tick(3, "drop_wait");
        bus.MASTER_EN = 1'b0;
        cycle("drop_master");
        chk("drop_snoozing", {1'b0, bus.SNOOZING}, 2'd0);
        bus.CT = mk_ct(2, 7, 31);
        cycle("drop_master");
        bus.MASTER_EN = 1'b1;
        cycle("drop_master");

        $display("step clear_with_match");
        clear = 1'b1;
        bus.CT = mk_ct(2, 7, 30);
        repeat (2) cycle("clear_hold");
        clear = 1'b0;
        repeat (3) cycle("clear_release");
        chk("clear_release_ring", {1'b0, bus.RING}, 2'd0);
        bus.Q_r3 = {1'b1, hm(7, 30)};
        fire(3, "next_day");
        chk("next_day_ring", {1'b0, bus.RING}, 2'd1);

        $display("step clear_mid_ring");
        press(1'b0, 1'b1, "mid_snz1");
        tick(SNOOZE_MIN, "mid_wait1");
        press(1'b0, 1'b1, "mid_snz2");
        tick(SNOOZE_MIN, "mid_wait2");
        chk("mid_ring_cnt", bus.SNOOZE_CNT, 2'd2);
        clear = 1'b1;
        cycle("mid_clear");
        chk("mid_clear_ring", {1'b0, bus.RING}, 2'd0);
        chk("mid_clear_cnt", bus.SNOOZE_CNT, 2'd0);
        clear = 1'b0;
        cycle("mid_release");

        $display("step random");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)
                bus.CT = mk_ct(int'($urandom_range(0, 7)), 7, 29 + int'($urandom_range(0, 1)));
            if ($urandom_range(0, 60) == 0) begin
                bus.Q_r2 = {1'($urandom_range(0, 1)), hm(7, 30)};
                bus.Q_r3 = {1'($urandom_range(0, 1)), hm(7, 30)};
            end
            bus.MIN_TICK  = ($urandom_range(0, 3) == 0);
            bus.STOP      = ($urandom_range(0, 60) == 0);
            bus.SNOOZE    = ($urandom_range(0, 12) == 0);
            bus.MASTER_EN = ($urandom_range(0, 300) != 0);
            clear         = ($urandom_range(0, 800) == 0);
            cycle("rand");
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
